// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: the entry carried from fetch to decode and the NOP
// word substituted for misaligned fetches.
package fetch_unit_pkg;

  localparam int unsigned XLen            = 32;
  localparam int unsigned InstructionSize = 32;
  localparam int unsigned FifoDepth       = 2;
  localparam int unsigned CountWidth      = 2;

  localparam logic [InstructionSize-1:0] NopInstr = 32'h00000013;

  typedef struct packed {
    logic [XLen-1:0]            pc;
    logic [XLen-1:0]            pc_plus4;
    logic [InstructionSize-1:0] instr;
    logic                       misaligned;
  } fetch_entry_t;

  // A misaligned PC never reaches decode as a real word; it becomes a NOP plus a flag.
  function automatic fetch_entry_t make_entry(input logic [XLen-1:0]            pc,
                                              input logic [InstructionSize-1:0] word);
    fetch_entry_t e;
    e.pc         = pc;
    e.pc_plus4   = pc + 32'd4;
    e.misaligned = (pc[1:0] != 2'b00);
    e.instr      = e.misaligned ? NopInstr : word;
    return e;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry circular FIFO of fetch entries with flush; head is read straight
// from storage so it stays stable while decode stalls.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  fetch_entry_t          push_entry,
  output fetch_entry_t          head,
  output logic [CountWidth-1:0] count
);

  fetch_entry_t slots [FifoDepth];
  logic         wr_ptr;
  logic         rd_ptr;

  // Flush only rewinds the pointers; stale slot data is hidden behind count==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + CountWidth'(push) - CountWidth'(pop);
    end
  end

  assign head = slots[rd_ptr];

  overflow_chk : assert property (@(posedge clk) disable iff (rst)
    !(!flush && count == CountWidth'(FifoDepth) && push && !pop))
    else $error("fetch_unit_fifo: push into full FIFO without pop");

  underflow_chk : assert property (@(posedge clk) disable iff (rst)
    !(!flush && count == '0 && pop))
    else $error("fetch_unit_fifo: pop from empty FIFO");

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, addresses the combinational instruction
// memory, and buffers fetched words for decode; redirects flush and reload.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned N_INSTR  = 32,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned AddrSize = $clog2(N_INSTR * 4)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [AddrSize-1:0] imem_addr,
  input  logic [31:0]         imem_instr,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_pc_plus4,
  output logic                out_misaligned
);

  logic [31:0]           pc;
  logic [CountWidth-1:0] count;
  logic                  push;
  logic                  pop;
  fetch_entry_t          fetched;
  fetch_entry_t          head;

  // A pop frees a slot in the same cycle, so a full FIFO still streams 1/cycle.
  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && ((count < CountWidth'(FifoDepth)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  assign imem_addr = pc[AddrSize-1:0];
  assign fetched   = make_entry(pc, imem_instr);

  fetch_unit_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .pop        (pop),
    .push_entry (fetched),
    .head       (head),
    .count      (count)
  );

  assign out_valid      = (count != '0);
  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign out_pc_plus4   = head.pc_plus4;
  assign out_misaligned = head.misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect/reset
// traffic, with a negedge monitor scoring every handshake against a stream model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned NInstr   = 32;
  localparam int unsigned AddrSize = $clog2(NInstr * 4);

  logic                clk = 1'b0;
  logic                rst;
  logic [AddrSize-1:0] imem_addr;
  logic [31:0]         imem_instr;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [31:0]         out_pc;
  logic [31:0]         out_pc_plus4;
  logic                out_misaligned;

  logic [31:0] mem [NInstr];
  int total = 0;
  int bad   = 0;
  int hs    = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[AddrSize-1:2]];

  fetch_unit #(.N_INSTR(NInstr), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_misaligned (out_misaligned)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what decode should see for a given PC, from the ISA-level rules.
  function automatic fetch_entry_t ref_entry(input logic [31:0] pc);
    fetch_entry_t e;
    logic [4:0]   widx;
    widx         = 5'((pc / 32'd4) % NInstr);
    e.pc         = pc;
    e.pc_plus4   = pc + 32'd4;
    e.misaligned = (pc % 32'd4) != 32'd0;
    e.instr      = e.misaligned ? 32'h00000013 : mem[widx];
    return e;
  endfunction

  // Expected stream: consecutive PCs from the last reset/redirect, consumed in order.
  fetch_entry_t exp_q[$];
  logic [31:0]  next_pc = 32'h0;
  int           quiet   = 0;

  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst) begin
      exp_q.delete();
      next_pc = 32'h0;
      quiet   = 0;
      check("reset_valid", 32'(out_valid), 32'd0);
    end else begin
      while (exp_q.size() < 2) begin
        exp_q.push_back(ref_entry(next_pc));
        next_pc = next_pc + 32'd4;
      end
      if (quiet >= 2) check("stream_live", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("hs_pc", out_pc, e.pc);
        check("hs_pc_plus4", out_pc_plus4, e.pc_plus4);
        check("hs_instr", out_instr, e.instr);
        check("hs_misaligned", 32'(out_misaligned), 32'(e.misaligned));
        hs++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        next_pc = redirect_pc;
        quiet   = 0;
      end else begin
        quiet++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(NInstr); i++) mem[i] = $urandom;
    mem[0]  = 32'h00500113;
    mem[1]  = 32'h00C00193;
    mem[2]  = 32'hFF718393;
    mem[4]  = 32'h0041F2B3;
    mem[31] = 32'h00100073;

    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_pc_plus4", out_pc_plus4, 32'h0);
    check("rst_misaligned", 32'(out_misaligned), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0);

    // Streaming from reset, one instruction per cycle.
    rst = 1'b0;
    tick();
    check("s1_valid", 32'(out_valid), 32'd1);
    check("s1_pc0", out_pc, 32'h0);
    check("s1_instr0", out_instr, 32'h00500113);
    check("s1_pc4_0", out_pc_plus4, 32'h4);
    tick();
    check("s1_pc1", out_pc, 32'h4);
    check("s1_instr1", out_instr, 32'h00C00193);
    tick();
    check("s1_pc2", out_pc, 32'h8);
    check("s1_instr2", out_instr, 32'hFF718393);
    check("s1_pc4_2", out_pc_plus4, 32'hC);

    // Decode stalled from reset: FIFO saturates at two entries.
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("s2_valid", 32'(out_valid), 32'd1);
    check("s2_head", out_pc, 32'h0);
    check("s2_pcreg", 32'(imem_addr), 32'h8);
    out_ready = 1'b1;
    tick();
    check("s2_next1", out_pc, 32'h4);
    tick();
    check("s2_next2", out_pc, 32'h8);

    // Redirect while full.
    out_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check("s3_flushed", 32'(out_valid), 32'd0);
    tick();
    check("s3_valid", 32'(out_valid), 32'd1);
    check("s3_pc", out_pc, 32'h10);
    check("s3_instr", out_instr, 32'h0041F2B3);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("s4_pc", out_pc, 32'h6);
    check("s4_instr", out_instr, 32'h00000013);
    check("s4_mis", 32'(out_misaligned), 32'd1);
    check("s4_nextpc", 32'(imem_addr), 32'hA);
    out_ready = 1'b1;
    tick();
    check("s4_pc_next", out_pc, 32'hA);
    check("s4_mis_next", 32'(out_misaligned), 32'd1);

    // Asynchronous reset while full.
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("s5_valid", 32'(out_valid), 32'd0);
    check("s5_pc", out_pc, 32'h0);
    check("s5_instr", out_instr, 32'h0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("s5_first_pc", out_pc, 32'h0);
    check("s5_first_instr", out_instr, 32'h00500113);

    // PC wrap at 2^32 and address aliasing.
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("s6_pc", out_pc, 32'hFFFF_FFFC);
    check("s6_pc_plus4", out_pc_plus4, 32'h0);
    check("s6_instr", out_instr, 32'h00100073);
    out_ready = 1'b1;
    tick();
    check("s6_wrap_pc", out_pc, 32'h0);
    check("s6_wrap_instr", out_instr, 32'h00500113);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'($urandom_range(0, 127));
        2:       redirect_pc = 32'($urandom_range(0, 31)) * 32'd4;
        default: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("handshake_volume", 32'(hs > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
